// File: rtl/regfile_bank.sv
// Parameterised register file with a power-on sweep that zeroes every entry
// (stack pointer excepted) before writes are accepted; reads are combinational.
module regfile_bank #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int SP_IDX  = 2,
  parameter int SP_INIT = 64,
  parameter int BYPASS  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0]      r_reg,
  output logic [NRD*XLEN-1:0]               r_dat,
  input  logic                              write,
  input  logic [$clog2(NREGS)-1:0]          w_reg,
  input  logic [XLEN-1:0]                   w_dat,
  output logic                              ready
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0]     CNT_LAST  = (AW+1)'(NREGS - 1);
  localparam logic [AW:0]     CNT_SP    = (AW+1)'(SP_IDX);
  localparam logic [XLEN-1:0] SP_VALUE  = XLEN'(SP_INIT);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    regs_d  = regs_q;
    unique case (state_q)
      ST_INIT: begin
        regs_d[cnt_q[AW-1:0]] = (cnt_q == CNT_SP) ? SP_VALUE : '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      ST_READY: begin
        if (write && (w_reg != '0)) begin
          regs_d[w_reg] = w_dat;
        end
      end
    endcase
  end

  // Array contents are deliberately left untouched by reset: the sweep defines them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      regs_q  <= regs_d;
    end
  end

  assign ready = ready_q;

  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;

  always_comb begin
    r_dat   = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_addr = r_reg[i*AW +: AW];
      rd_val  = '0;
      if ((state_q == ST_READY) && (rd_addr != '0)) begin
        if ((BYPASS != 0) && write && (w_reg == rd_addr)) begin
          rd_val = w_dat;
        end else begin
          rd_val = regs_q[rd_addr];
        end
      end
      r_dat[i*XLEN +: XLEN] = rd_val;
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Randomised bench for regfile_bank: a forwarding 4-port instance and a
// non-forwarding 2-port instance share stimulus and one reference model.
module tb_regfile_bank;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              write;
  logic [AW-1:0]     w_reg;
  logic [XLEN-1:0]   w_dat;
  logic [AW-1:0]     ra [4];
  logic [4*AW-1:0]   r_reg_a;
  logic [2*AW-1:0]   r_reg_b;
  logic [4*XLEN-1:0] r_dat_a;
  logic [2*XLEN-1:0] r_dat_b;
  logic              ready_a, ready_b;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_ready;
  int              m_cnt;

  assign r_reg_a = {ra[3], ra[2], ra[1], ra[0]};
  assign r_reg_b = {ra[1], ra[0]};

  always #5 clk = ~clk;

  regfile_bank #(.XLEN(XLEN), .NREGS(NREGS), .NRD(4), .SP_IDX(2), .SP_INIT(64), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .r_reg(r_reg_a), .r_dat(r_dat_a),
    .write(write), .w_reg(w_reg), .w_dat(w_dat), .ready(ready_a)
  );

  regfile_bank #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .SP_IDX(2), .SP_INIT(64), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .r_reg(r_reg_b), .r_dat(r_dat_b),
    .write(write), .w_reg(w_reg), .w_dat(w_dat), .ready(ready_b)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!m_ready || a == 0) return '0;
    if (byp && write && w_reg == a) return w_dat;
    return m_regs[a];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_ready = 0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      m_regs[m_cnt] = (m_cnt == 2) ? 32'd64 : 32'd0;
      m_cnt++;
      if (m_cnt == NREGS) m_ready = 1;
    end else if (write && w_reg != 0) begin
      m_regs[w_reg] = w_dat;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, ".ready_a"}, {31'd0, ready_a}, {31'd0, m_ready});
    check({tag, ".ready_b"}, {31'd0, ready_b}, {31'd0, m_ready});
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.a%0d", tag, i), r_dat_a[i*XLEN +: XLEN], exp_rd(ra[i], 1'b1));
    for (int i = 0; i < 2; i++)
      check($sformatf("%s.b%0d", tag, i), r_dat_b[i*XLEN +: XLEN], exp_rd(ra[i], 1'b0));
  endtask

  task automatic set_reads(input int a0, input int a1, input int a2, input int a3);
    ra[0] = AW'(a0); ra[1] = AW'(a1); ra[2] = AW'(a2); ra[3] = AW'(a3);
  endtask

  int edges;

  initial begin
    for (int k = 0; k < NREGS; k++) m_regs[k] = 'x;
    m_ready = 0; m_cnt = 0;
    rst_n = 1'b0; write = 1'b1; w_reg = 5'd9; w_dat = 32'hA5A5A5A5;
    set_reads(2, 9, 5, 31);
    #2;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("reset");
    end

    // sweep with a write presented throughout: must be ignored
    rst_n = 1'b1; w_reg = 5'd3; w_dat = 32'd5;
    set_reads(3, 2, 7, 0);
    for (int k = 0; k < NREGS; k++) begin
      check_all("sweep");
      tick();
    end
    check({"ready_after_32"}, {31'd0, ready_a}, 32'd1);
    write = 1'b0;
    set_reads(2, 2, 2, 2);
    check_all("sp_all_ports");
    check("sp_literal", r_dat_a[3*XLEN +: XLEN], 32'd64);
    set_reads(5, 3, 5, 3);
    check_all("zero_regs");
    check("init_write_dropped", r_dat_a[XLEN +: XLEN], 32'd0);

    // write-cycle forwarding vs pre-write value
    write = 1'b1; w_reg = 5'd7; w_dat = 32'hDEADBEEF;
    set_reads(7, 7, 1, 7);
    check_all("bypass_cycle");
    check("bypass_lit", r_dat_a[XLEN-1:0], 32'hDEADBEEF);
    check("nobypass_lit", r_dat_b[XLEN-1:0], 32'd0);
    tick();
    write = 1'b0;
    check_all("after_write");
    check("nobypass_next", r_dat_b[XLEN-1:0], 32'hDEADBEEF);

    // register 0 is hardwired zero
    write = 1'b1; w_reg = 5'd0; w_dat = 32'hFFFFFFFF;
    set_reads(0, 0, 0, 0);
    check_all("r0_write");
    tick();
    write = 1'b0;
    check_all("r0_later");
    tick();
    check_all("r0_later2");

    // random traffic, biased towards same-address read/write
    for (int k = 0; k < 300; k++) begin
      write = 1'($urandom_range(0, 1));
      w_reg = AW'($urandom_range(0, 31));
      w_dat = $urandom;
      for (int p = 0; p < 4; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? w_reg : AW'($urandom_range(0, 31));
      check_all("rand");
      tick();
    end

    // mid-sweep reset after prior contents
    write = 1'b1; w_reg = 5'd7; w_dat = 32'h1234;
    tick();
    write = 1'b0; set_reads(7, 2, 0, 31);
    check_all("pre_reset_r7");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("midsweep_cnt", 32'(m_cnt), 32'd10);
    write = 1'b1; w_reg = 5'd7; w_dat = 32'hBAD0BAD0;
    rst_n = 1'b0;
    tick();
    check_all("midsweep_reset");
    rst_n = 1'b1;
    edges = 0;
    while (!ready_a && edges < 100) begin
      check_all("resweep");
      tick();
      edges++;
    end
    check("resweep_edges", 32'(edges), 32'd32);
    write = 1'b0;
    set_reads(7, 7, 2, 7);
    check_all("resweep_r7");
    check("r7_cleared", r_dat_a[XLEN-1:0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, at least 4; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of combinational read ports, 1 to 4.
REQ-004 SHALL have parameter SP_IDX, default 2: index of the stack-pointer register.
REQ-005 SHALL have parameter SP_INIT, default 64: value loaded into register SP_IDX at init.
REQ-006 SHALL have parameter BYPASS, default 1: 1 means write-to-read forwarding is enabled.
REQ-007 SHALL use one clock; reset is synchronous and active-low.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  synchronous active-low reset.
REQ-010 r_reg  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-011 r_dat  out  NRD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
REQ-012 write  in  1  write enable.
REQ-013 w_reg  in  AW  write address.
REQ-014 w_dat  in  XLEN  write data.
REQ-015 ready  out  1  high once the init sweep is complete and the file accepts writes.

Function
REQ-016 SHALL implement a two-state FSM: INIT and READY.
REQ-017 SHALL hold state INIT and sweep counter cnt = 0 on any rising edge where rst_n = 0.
REQ-018 In INIT, on each rising edge with rst_n = 1: SHALL write regs[cnt] = (cnt == SP_IDX ? SP_INIT : 0), then increment cnt.
REQ-019 SHALL move from INIT to READY on the edge that writes cnt = NREGS-1; ready is therefore high exactly NREGS edges after rst_n rises.
REQ-020 SHALL keep READY until rst_n = 0; there is no other exit from READY.
REQ-021 SHALL drive ready = 1 only in state READY.
REQ-022 SHALL ignore write while in INIT: no array update and no forwarding.
REQ-023 In READY, SHALL write regs[w_reg] = w_dat on the rising edge when write = 1 and w_reg != 0.
REQ-024 SHALL treat register 0 as hardwired zero: writes to it are discarded and reads of it return 0 from all ports.
REQ-025 SHALL make reads combinational: r_dat port i = regs[r_reg port i], with zero latency.
REQ-026 SHALL drive all r_dat ports to 0 while in INIT, regardless of array contents.
REQ-027 With BYPASS = 1, in READY, SHALL forward w_dat to port i when write = 1, w_reg = r_reg port i, and w_reg != 0.
REQ-028 With BYPASS = 0, SHALL return the pre-write array value in the same cycle; the new value is visible from the next cycle.
REQ-029 SHALL let all read ports read the same address simultaneously, each returning identical data.
REQ-030 SHALL, if rst_n is asserted mid-sweep, restart the sweep from cnt = 0; partially initialised contents are overwritten on the restart.
REQ-031 SHALL, if rst_n is asserted while a write is presented, discard that write.
REQ-032 SHALL make cnt AW+1 bits wide so it does not wrap before the INIT-to-READY transition.

Reset
REQ-033 While rst_n = 0: state = INIT, cnt = 0, ready = 0, and all r_dat ports = 0.
REQ-034 After reset release and the NREGS-edge sweep: every regs[k] = 0 except regs[SP_IDX] = SP_INIT, and ready = 1.
REQ-035 SHALL have no dependence on simulation initial blocks for contents; the sweep alone defines contents.

Verification
REQ-036 Defaults; hold rst_n = 0 for 3 edges, then release -> ready = 0 for 31 edges and ready = 1 after the 32nd; reading address 2 returns 64, reading address 5 returns 0.
REQ-037 In READY: write = 1, w_reg = 7, w_dat = 0xDEADBEEF; same cycle r_reg0 = 7 -> r_dat0 = 0xDEADBEEF (BYPASS = 1); next cycle, with write = 0, r_dat0 = 0xDEADBEEF.
REQ-038 Same stimulus with BYPASS = 0 -> r_dat0 = 0 in the write cycle and 0xDEADBEEF in the next cycle.
REQ-039 Write w_reg = 0, w_dat = 0xFFFFFFFF with r_reg0 = r_reg1 = 0 -> both read ports return 0 in the write cycle and every later cycle.
REQ-040 Assert rst_n = 0 at sweep cnt = 10 after prior contents reg 7 = 0x1234, then release -> ready rises 32 edges later and reg 7 reads 0.
REQ-041 During INIT, write = 1, w_reg = 3, w_dat = 5 -> reg 3 reads 0 after ready rises; NRD = 4, all ports r_reg = 2 -> all four return 64.
